// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined ripple-carry adder.
// Both the slice width and the parameter-legality check are derived here.
package adder_pkg;

  localparam int MODE_UNSIGNED = 0;
  localparam int MODE_SIGNED   = 1;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit params_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Bit-level full adder built from two half adders plus an OR.
// The half adder is kept as its own cell so the structure maps one-to-one onto gates.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;

endmodule

module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.a_i(a_i), .b_i(b_i), .sum_o(s0),    .carry_o(c0));
  half_adder u_ha1 (.a_i(s0),  .b_i(c_i), .sum_o(sum_o), .carry_o(c1));

  // Both half-adder carries can never be high together, so OR equals XOR here.
  assign carry_o = c0 | c1;

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder: one SW-bit slice resolved per stage, carry registered
// between slices, unconsumed operand bits skewed forward and finished sum bits deskewed.
module pipelined_rca_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4,
  parameter int SIGNED = MODE_SIGNED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW   = slice_w(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  if (!params_ok(WIDTH, STAGES)) begin : g_param_check
    $fatal(1, "pipelined_rca_adder: need WIDTH >= 2, 1 <= STAGES <= WIDTH, WIDTH %% STAGES == 0");
  end

  logic advance;

  // Global stall: every stage moves together or none does.
  assign advance  = !out_valid || out_ready;
  // Reset empties the pipe, so the source may be told it is ready while rst is high.
  assign in_ready = rst || advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN_W  = WIDTH - k * SW;
    localparam int OUT_W = (k + 1) * SW;

    logic [IN_W-1:0]  a_in;
    logic [IN_W-1:0]  b_in;
    logic             carry_in;
    logic             valid_d;
    logic             amsb_d;
    logic             bmsb_d;
    logic [OUT_W-1:0] sum_d;
    logic [SW:0]      c;
    logic [SW-1:0]    s;

    logic             valid_q;
    logic             carry_q;
    logic             amsb_q;
    logic             bmsb_q;
    logic [OUT_W-1:0] sum_q;

    if (k == 0) begin : g_head
      assign a_in     = a;
      assign b_in     = b;
      assign carry_in = cin;
      assign valid_d  = in_valid;
      assign amsb_d   = a[WIDTH-1];
      assign bmsb_d   = b[WIDTH-1];
      assign sum_d    = s;
    end else begin : g_link
      assign a_in     = g_stage[k-1].g_skew.a_q;
      assign b_in     = g_stage[k-1].g_skew.b_q;
      assign carry_in = g_stage[k-1].carry_q;
      assign valid_d  = g_stage[k-1].valid_q;
      assign amsb_d   = g_stage[k-1].amsb_q;
      assign bmsb_d   = g_stage[k-1].bmsb_q;
      assign sum_d    = {s, g_stage[k-1].sum_q};
    end

    assign c[0] = carry_in;

    for (genvar i = 0; i < SW; i++) begin : g_bit
      fa_cell u_fa (
        .a_i    (a_in[i]),
        .b_i    (b_in[i]),
        .c_i    (c[i]),
        .sum_o  (s[i]),
        .carry_o(c[i+1])
      );
    end

    // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        amsb_q  <= 1'b0;
        bmsb_q  <= 1'b0;
        sum_q   <= '0;
      end else if (advance) begin
        valid_q <= valid_d;
        carry_q <= c[SW];
        amsb_q  <= amsb_d;
        bmsb_q  <= bmsb_d;
        sum_q   <= sum_d;
      end
    end

    // Only operand bits above this slice still need to travel downstream.
    if (IN_W > SW) begin : g_skew
      logic [IN_W-SW-1:0] a_q;
      logic [IN_W-SW-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_in[IN_W-1:SW];
          b_q <= b_in[IN_W-1:SW];
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].valid_q;
  assign sum       = g_stage[LAST].sum_q;
  assign cout      = g_stage[LAST].carry_q;

  if (SIGNED == MODE_SIGNED) begin : g_ovf_signed
    assign ovf = (g_stage[LAST].amsb_q == g_stage[LAST].bmsb_q) &&
                 (sum[WIDTH-1] != g_stage[LAST].amsb_q);
  end else begin : g_ovf_unsigned
    assign ovf = cout;
  end

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Self-checking bench: directed table, hand-written timing sequences and a randomized
// stream compared against an arithmetic reference model through a scoreboard queue.
module tb_pipelined_rca_adder;

  localparam int W  = 16;
  localparam int ST = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         ovf_u;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         ovf_u;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic         in_ready,  in_ready_u;
  logic         out_valid, out_valid_u;
  logic [W-1:0] sum,       sum_u;
  logic         cout,      cout_u;
  logic         ovf,       ovf_u;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipelined_rca_adder #(.WIDTH(W), .STAGES(ST), .SIGNED(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_rca_adder #(.WIDTH(W), .STAGES(ST), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid_u), .out_ready(out_ready),
    .sum(sum_u), .cout(cout_u), .ovf(ovf_u)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
    exp_t e;
    int   tot;
    int   sa;
    int   sb;
    int   st;
    tot     = int'(ai) + int'(bi) + int'(ci);
    e.sum   = tot[W-1:0];
    e.cout  = tot[W];
    sa      = ai[W-1] ? int'(ai) - 65536 : int'(ai);
    sb      = bi[W-1] ? int'(bi) - 65536 : int'(bi);
    st      = sa + sb + int'(ci);
    e.ovf   = (st > 32767) || (st < -32768);
    e.ovf_u = e.cout;
    return e;
  endfunction

  // Scoreboard: sampled on the falling edge, i.e. the values the next rising edge will see.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      exp_q.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_beat", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_sum",   sum,   e.sum);
          check("sb_cout",  cout,  e.cout);
          check("sb_ovf",   ovf,   e.ovf);
          check("sb_sum_u", sum_u, e.sum);
          check("sb_ovf_u", ovf_u, e.ovf_u);
        end
        n_out++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) exp_q.push_back(model(a, b, cin));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input vec_t v, input string tag);
    int lat;
    out_ready = 1'b1;
    a         = v.a;
    b         = v.b;
    cin       = v.cin;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat,   ST);
    check({tag, "_sum"},     sum,   v.sum);
    check({tag, "_cout"},    cout,  v.cout);
    check({tag, "_ovf"},     ovf,   v.ovf);
    check({tag, "_ovf_u"},   ovf_u, v.ovf_u);
    tick();
  endtask

  initial begin
    vec_t tbl[8];
    exp_t ex;
    exp_t first;
    logic acc;
    logic exp_v;
    logic acc_h[0:31];
    int   bi;
    int   stall_left;
    bit   stalled;
    int   out0;
    int   n_acc;
    int   guard;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    tick();
    tick();
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum",       sum,       0);
    check("rst_cout",      cout,      0);
    check("rst_ovf",       ovf,       0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) run_single(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back throughput: beat i accepted at edge i+1, emerges after edge i+4.
    for (int e = 1; e <= 16; e++) begin
      if (e <= 8) begin
        a        = 16'((e - 1) * 16'h1111);
        b        = 16'h0F0F;
        cin      = 1'((e - 1) % 2);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      exp_v = (e >= 4) && (e <= 11);
      check("tp_valid", out_valid, exp_v);
      if (exp_v) begin
        ex = model(16'((e - 4) * 16'h1111), 16'h0F0F, 1'((e - 4) % 2));
        check("tp_sum", sum, ex.sum);
      end
    end

    // Backpressure: drop out_ready for 3 cycles once the first result shows up.
    out0       = n_out;
    bi         = 0;
    stall_left = 0;
    stalled    = 0;
    first      = model(16'h00F0, 16'hF00F, 1'b0);
    for (int c = 0; c < 30; c++) begin
      in_valid  = (bi < 6);
      a         = 16'(bi * 16'h0101 + 16'h00F0);
      b         = 16'hF00F;
      cin       = 1'(bi % 2);
      out_ready = (stall_left == 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (stall_left > 0) begin
        check("bp_in_ready",  in_ready,  0);
        check("bp_out_valid", out_valid, 1);
        check("bp_hold_sum",  sum,       first.sum);
        check("bp_hold_cout", cout,      first.cout);
        check("bp_hold_ovf",  ovf,       first.ovf);
        stall_left--;
      end
      @(posedge clk);
      #1;
      if (acc) bi++;
      if (!stalled && out_valid === 1'b1) begin
        stalled    = 1;
        stall_left = 3;
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    check("bp_beats_out", n_out - out0,  6);
    check("bp_sb_empty",  exp_q.size(),  0);

    // Bubbles: alternating in_valid must reappear 3 edges later.
    for (int e = 1; e <= 16; e++) begin
      in_valid = (e <= 8) && (e % 2 == 1);
      a        = 16'($urandom);
      b        = 16'($urandom);
      cin      = 1'($urandom);
      acc_h[e] = in_valid;
      tick();
      check("bub_valid", out_valid, (e >= 4) ? acc_h[e-3] : 1'b0);
    end
    in_valid = 1'b0;

    // Reset mid-flight: three beats in the pipe, then a one-cycle reset.
    for (int i = 0; i < 3; i++) begin
      a        = 16'(16'h0101 * (i + 1));
      b        = 16'h1111;
      cin      = 1'b1;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum",       sum,       0);
    check("mid_rst_cout",      cout,      0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid_rst_no_beat", out_valid, 0);
    end
    run_single('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0}, "after_rst");

    // Randomized stream with random backpressure; the source holds unaccepted beats.
    out0     = n_out;
    n_acc    = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) n_acc++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard     = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      tick();
      guard++;
    end
    check("rand_drain_empty", exp_q.size(),  0);
    check("rand_beat_count",  n_out - out0,  n_acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_rca_adder.md
Name: pipelined_rca_adder

Overview:
- Parametrised, pipelined ripple-carry adder built from a bit-level full-adder cell; each full adder is two half adders plus an OR.
- The WIDTH-bit add is split into STAGES equal slices. One slice is resolved per clock, and the carry is registered between slices.
- Valid/ready handshake on both sides. Sits between operand sources and accumulator/ALU datapaths that need high clock rate at full throughput.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be ≥ 2.
- STAGES, 4, number of pipeline stages. Must divide WIDTH exactly; 1 ≤ STAGES ≤ WIDTH.
- SIGNED, 1, 1 = ovf reports two's-complement overflow; 0 = ovf reports unsigned overflow (equals cout).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  overflow flag per SIGNED.

Behaviour:
- Slice width is SW = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k*SW +: SW] of the skewed a/b using SW chained full-adder cells. Carry-in to stage k:
  - k = 0: cin.
  - k > 0: the carry registered by stage k-1.
- Per-stage registers:
  - valid bit;
  - carry;
  - the sum bits produced so far (lower slices, deskew);
  - the a/b bits not yet consumed (upper slices, skew).
- Stage 0 also registers a[WIDTH-1] and b[WIDTH-1]. These travel with the beat for ovf computation.
- Stall rule (global stall): advance = !out_valid || out_ready; in_ready = advance.
  - When advance = 0, every stage register holds, including valid bits.
  - When advance = 1, all stages shift by one.
  - Bubbles are not compressed.
- Acceptance: a beat is accepted when in_valid && in_ready. A beat offered while in_ready = 0 is not captured; the source holds it.
- Latency: exactly STAGES cycles from acceptance to out_valid with no stall; STAGES = 1 gives a one-register adder.
- Throughput: one beat per cycle when out_ready is held high.
- Outputs: sum, cout and ovf come directly from the final stage registers and are stable while out_valid && !out_ready.
- ovf:
  - SIGNED = 1: ovf = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb), where cin counts toward the sum.
  - SIGNED = 0: ovf = cout.
- Reset: rst = 1 clears all valid bits, carries and data registers to 0.
  - out_valid = 0, sum = 0, cout = 0, ovf = 0 from the cycle after rst is sampled high.
  - in_ready = 1 during and after reset (the pipe is empty).
  - Reset mid-operation discards all in-flight beats; no partial result ever appears.
- Bit-serial carry: the carry is correct across all slice boundaries, including full propagation through every slice (e.g. all-ones + 1).
- in_valid = 0 with advance = 1 inserts a bubble; the valid bit of stage 0 becomes 0.
- No state machine beyond the per-stage valid bits; no combinational path from in_valid to out_valid.

Decomposition:
- Shared package adder_pkg:
  - stage-width function slice_w(WIDTH, STAGES);
  - elaboration-time check that WIDTH % STAGES == 0 (fatal otherwise);
  - SIGNED mode constants (MODE_UNSIGNED = 0, MODE_SIGNED = 1).
- Sub-module fa_cell: one-bit full adder composed of two half-adder instances plus OR. It is instantiated SW times per stage via generate.
- The pipeline registers stay in pipelined_rca_adder.

Test Plan (WIDTH = 16, STAGES = 4, SIGNED = 1 unless stated):
- Full carry ripple: a = 0xFFFF, b = 0x0001, cin = 0 -> 4 cycles later out_valid = 1, sum = 0x0000, cout = 1, ovf = 0.
- Signed overflow and cin: a = 0x7FFF, b = 0x0000, cin = 1 -> sum = 0x8000, cout = 0, ovf = 1. With SIGNED = 0, the same stimulus -> ovf = 0.
- Back-to-back throughput: 8 consecutive beats (a = i*0x1111, b = 0x0F0F, cin = i%2) with out_ready = 1.
  - Results appear on 8 consecutive cycles starting at cycle 4, in order, each matching a + b + cin.
- Backpressure: stream 6 beats and drop out_ready for 3 cycles while out_valid = 1.
  - in_ready = 0 for those 3 cycles; sum/cout/ovf hold.
  - No beat is lost or duplicated; order is preserved.
- Bubbles: alternate in_valid 1/0 -> out_valid alternates 1/0 with 4-cycle latency.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle at cycle 2.
  - out_valid = 0 and sum = 0 the next cycle; no result emerges for the 3 beats.
  - A new beat 0x1234 + 0x4321 after reset -> sum = 0x5555, 4 cycles later.
